// File: rtl/ide_device_pio_pkg.sv
// Shared definitions for the ATA PIO device responder: task-file register
// indices, command opcodes, status bit positions, error codes and the
// controller state type.
package ide_pkg;

  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_ERR   = 3'd1;  // error (rd) / features (wr)
  localparam logic [2:0] REG_COUNT = 3'd2;
  localparam logic [2:0] REG_LBA0  = 3'd3;
  localparam logic [2:0] REG_LBA1  = 3'd4;
  localparam logic [2:0] REG_LBA2  = 3'd5;
  localparam logic [2:0] REG_DEV   = 3'd6;
  localparam logic [2:0] REG_CMD   = 3'd7;  // status (rd) / command (wr)

  localparam logic [7:0] CMD_READ  = 8'h20;
  localparam logic [7:0] CMD_WRITE = 8'h30;

  localparam int unsigned ST_BSY  = 7;
  localparam int unsigned ST_DRDY = 6;
  localparam int unsigned ST_DRQ  = 3;
  localparam int unsigned ST_ERR  = 0;

  localparam logic [7:0] ERR_ABRT = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_FETCH,
    S_RD_DRQ,
    S_WR_DRQ,
    S_WR_FLUSH
  } ide_state_t;

endpackage

// File: rtl/ide_device_pio_if.sv
// IDE host bus plus backing-store word stream.
//   master : host/store side (drives strobes, write data, store responses)
//   slave  : the device responder
interface ide_device_pio_if #(
  parameter int unsigned LBA_W = 28
);
  logic             IDECS_n;
  logic [2:0]       DA;
  logic             IDERD_n;
  logic             IDEWR_n;
  logic [15:0]      DD_IN;
  logic [15:0]      DD_OUT;
  logic             DD_OE;
  logic             INTRQ;
  logic             ST_REQ;
  logic             ST_WR;
  logic [LBA_W-1:0] ST_LBA;
  logic [15:0]      ST_RDATA;
  logic             ST_RVALID;
  logic [15:0]      ST_WDATA;
  logic             ST_WREADY;

  modport master (
    output IDECS_n, DA, IDERD_n, IDEWR_n, DD_IN, ST_RDATA, ST_RVALID, ST_WREADY,
    input  DD_OUT, DD_OE, INTRQ, ST_REQ, ST_WR, ST_LBA, ST_WDATA
  );

  modport slave (
    input  IDECS_n, DA, IDERD_n, IDEWR_n, DD_IN, ST_RDATA, ST_RVALID, ST_WREADY,
    output DD_OUT, DD_OE, INTRQ, ST_REQ, ST_WR, ST_LBA, ST_WDATA
  );
endinterface

// File: rtl/ide_device_pio_sector_buf.sv
// 256x16 single-port sector buffer: synchronous write, asynchronous read so
// the host sees buffer[ptr] on DD_OUT while its read strobe is low.
//   clk   : clock
//   we    : write enable
//   addr  : word address (the owner's buffer pointer)
//   wdata : write word
//   rdata : word at addr
module ide_sector_buf (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  logic [15:0] mem [256];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/ide_device_pio.sv
// ATA PIO device responder: task-file registers, READ SECTORS and WRITE
// SECTORS through a 256-word sector buffer, backed by a word-stream store.
//   CPUCLK : single clock
//   RESET  : synchronous active-high reset
//   bus    : host IDE bus and store stream (slave modport)
module ide_device_pio
  import ide_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LBA_W       = 28
) (
  input logic             CPUCLK,
  input logic             RESET,
  ide_device_pio_if.slave bus
);
  logic [SYNC_STAGES-1:0] cs_sh, rd_sh, wr_sh;
  logic [2:0]             da_sh [SYNC_STAGES];
  logic                   rd_q, wr_q;

  ide_state_t       state;
  logic [7:0]       ptr;
  logic [7:0]       count;
  logic [LBA_W-1:0] lba;
  logic [7:0]       error_reg;
  logic             intrq, st_req, st_wr;

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      cs_sh <= '1;
      rd_sh <= '1;
      wr_sh <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) da_sh[i] <= '0;
      rd_q  <= 1'b1;
      wr_q  <= 1'b1;
    end else begin
      cs_sh    <= {cs_sh[SYNC_STAGES-2:0], bus.IDECS_n};
      rd_sh    <= {rd_sh[SYNC_STAGES-2:0], bus.IDERD_n};
      wr_sh    <= {wr_sh[SYNC_STAGES-2:0], bus.IDEWR_n};
      da_sh[0] <= bus.DA;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) da_sh[i] <= da_sh[i-1];
      rd_q     <= rd_sh[SYNC_STAGES-1];
      wr_q     <= wr_sh[SYNC_STAGES-1];
    end
  end

  // Side effects fire on the synchronised deassert of a strobe while selected.
  logic       rd_edge, wr_edge;
  logic [2:0] da_s;
  assign da_s    = da_sh[SYNC_STAGES-1];
  assign rd_edge = rd_sh[SYNC_STAGES-1] & ~rd_q & ~cs_sh[SYNC_STAGES-1];
  assign wr_edge = wr_sh[SYNC_STAGES-1] & ~wr_q & ~cs_sh[SYNC_STAGES-1];

  logic bsy, drq, tf_ok;
  logic [7:0] status;
  assign bsy    = (state == S_RD_FETCH) || (state == S_WR_FLUSH);
  assign drq    = (state == S_RD_DRQ) || (state == S_WR_DRQ);
  assign tf_ok  = !bsy && !drq;
  assign status = {bsy, 1'b1, 2'b00, drq, 2'b00, |error_reg};

  // Host data and store traffic never overlap: host only in DRQ states,
  // store only in BSY states, so the buffer port needs only a data mux.
  logic store_rd, store_wr, host_rd, host_wr, ptr_adv, sector_end, last_sector;
  assign store_rd    = (state == S_RD_FETCH) && st_req && bus.ST_RVALID;
  assign store_wr    = (state == S_WR_FLUSH) && st_req && bus.ST_WREADY;
  assign host_rd     = rd_edge && (da_s == REG_DATA) && (state == S_RD_DRQ);
  assign host_wr     = wr_edge && (da_s == REG_DATA) && (state == S_WR_DRQ);
  assign ptr_adv     = store_rd || store_wr || host_rd || host_wr;
  assign sector_end  = ptr_adv && (ptr == 8'hFF);
  assign last_sector = (count == 8'd1);

  logic        buf_we;
  logic [15:0] buf_wdata, buf_rdata;
  assign buf_we    = store_rd || host_wr;
  assign buf_wdata = store_rd ? bus.ST_RDATA : bus.DD_IN;

  ide_sector_buf u_buf (
    .clk   (CPUCLK),
    .we    (buf_we),
    .addr  (ptr),
    .wdata (buf_wdata),
    .rdata (buf_rdata)
  );

  logic [27:0] lba28, lba_tf;
  assign lba28 = 28'(lba);

  always_comb begin
    lba_tf = lba28;
    case (da_s)
      REG_LBA0: lba_tf[7:0]   = bus.DD_IN[7:0];
      REG_LBA1: lba_tf[15:8]  = bus.DD_IN[7:0];
      REG_LBA2: lba_tf[23:16] = bus.DD_IN[7:0];
      REG_DEV:  lba_tf[27:24] = bus.DD_IN[3:0];
      default:  ;
    endcase
  end

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      ptr       <= '0;
      count     <= 8'h01;
      lba       <= '0;
      error_reg <= '0;
      intrq     <= 1'b0;
      st_req    <= 1'b0;
      st_wr     <= 1'b0;
    end else begin
      if (ptr_adv) ptr <= ptr + 8'd1;
      if (rd_edge && da_s == REG_CMD) intrq <= 1'b0;
      if (wr_edge && tf_ok) begin
        if (da_s == REG_COUNT) count <= bus.DD_IN[7:0];
        if (da_s inside {REG_LBA0, REG_LBA1, REG_LBA2, REG_DEV}) lba <= LBA_W'(lba_tf);
      end
      case (state)
        S_IDLE: begin
          if (wr_edge && da_s == REG_CMD) begin
            case (bus.DD_IN[7:0])
              CMD_READ: begin
                state     <= S_RD_FETCH;
                st_req    <= 1'b1;
                st_wr     <= 1'b0;
                ptr       <= '0;
                error_reg <= '0;
                intrq     <= 1'b0;
              end
              CMD_WRITE: begin
                state     <= S_WR_DRQ;
                ptr       <= '0;
                error_reg <= '0;
                intrq     <= 1'b0;
              end
              default: begin
                error_reg <= ERR_ABRT;
                intrq     <= 1'b1;
              end
            endcase
          end
        end
        S_RD_FETCH: begin
          if (sector_end) begin
            state  <= S_RD_DRQ;
            st_req <= 1'b0;
            intrq  <= 1'b1;
          end
        end
        S_RD_DRQ: begin
          if (sector_end) begin
            count <= count - 8'd1;
            lba   <= lba + LBA_W'(1);
            if (last_sector) begin
              state <= S_IDLE;
            end else begin
              state  <= S_RD_FETCH;
              st_req <= 1'b1;
              st_wr  <= 1'b0;
            end
          end
        end
        S_WR_DRQ: begin
          if (sector_end) begin
            state  <= S_WR_FLUSH;
            st_req <= 1'b1;
            st_wr  <= 1'b1;
          end
        end
        S_WR_FLUSH: begin
          if (sector_end) begin
            st_req <= 1'b0;
            st_wr  <= 1'b0;
            count  <= count - 8'd1;
            lba    <= lba + LBA_W'(1);
            intrq  <= 1'b1;
            state  <= last_sector ? S_IDLE : S_WR_DRQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Host-visible read data follows the raw DA pins so it is valid during the strobe.
  always_comb begin
    bus.DD_OUT = '0;
    case (bus.DA)
      REG_DATA:  bus.DD_OUT = buf_rdata;
      REG_ERR:   bus.DD_OUT = {8'h00, error_reg};
      REG_COUNT: bus.DD_OUT = {8'h00, count};
      REG_LBA0:  bus.DD_OUT = {8'h00, lba28[7:0]};
      REG_LBA1:  bus.DD_OUT = {8'h00, lba28[15:8]};
      REG_LBA2:  bus.DD_OUT = {8'h00, lba28[23:16]};
      REG_DEV:   bus.DD_OUT = {8'h00, 4'b0100, lba28[27:24]};
      default:   bus.DD_OUT = {8'h00, status};
    endcase
  end

  assign bus.DD_OE    = !bus.IDECS_n && !bus.IDERD_n;
  assign bus.INTRQ    = intrq;
  assign bus.ST_REQ   = st_req;
  assign bus.ST_WR    = st_wr;
  assign bus.ST_LBA   = lba;
  assign bus.ST_WDATA = buf_rdata;
endmodule
